// File: rtl/tiler_pkg.sv
// Shared types, default geometry and block-packing helper for the raster block tiler.
package tiler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATHER  = 2'd1,
    PRESENT = 2'd2
  } rd_state_t;

  // Index width that stays at least one bit for degenerate single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pixel (r,c) of a b x b block lands at this slice; (0,0) sits in the MSBs.
  function automatic int slice_idx(input int b, input int r, input int c);
    return b * b - 1 - (r * b + c);
  endfunction

  localparam int DEF_B     = 8;
  localparam int DEF_IMG_W = 128;
  localparam int DEF_IMG_H = 128;
  localparam int BLKS_X    = DEF_IMG_W / DEF_B;
  localparam int BLKS_Y    = DEF_IMG_H / DEF_B;
  localparam int BLKS_X_W  = idx_w(BLKS_X);
  localparam int BLKS_Y_W  = idx_w(BLKS_Y);

endpackage

// File: rtl/tile_line_bank.sv
// Two ping-pong banks of B image rows; one pixel write port and a B-pixel
// combinational row read port starting at a block-aligned column.
module tile_line_bank
  import tiler_pkg::*;
#(
  parameter int N     = 16,
  parameter int B     = DEF_B,
  parameter int IMG_W = DEF_IMG_W
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic                   wr_bank,
  input  logic [idx_w(B)-1:0]    wr_row,
  input  logic [idx_w(IMG_W)-1:0] wr_col,
  input  logic [N-1:0]           wr_data,
  input  logic                   rd_bank,
  input  logic [idx_w(B)-1:0]    rd_row,
  input  logic [idx_w(IMG_W)-1:0] rd_base,
  output logic [N*B-1:0]         rd_data
);

  localparam int CW = idx_w(IMG_W);

  logic [N-1:0] mem [2][B][IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_row][wr_col] <= wr_data;
  end

  // Column base+c goes to the upper slices so the leftmost pixel is in the MSBs.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < B; c++) begin
      rd_data[(B-1-c)*N +: N] = mem[rd_bank][rd_row][rd_base + CW'(c)];
    end
  end

endmodule

// File: rtl/raster_block_tiler.sv
// Raster-to-block front end for dct2d: buffers B rows per bank and emits BxB blocks.
// Optional CC_LEVEL_SHIFT_EN subtracts LEVEL_SHIFT from every pixel before storage.
//
// state   | meaning
// IDLE    | waiting for the read bank to be full
// GATHER  | copying one block row per cycle into the block register
// PRESENT | block offered on out_*, waiting for out_ready
module raster_block_tiler
  import tiler_pkg::*;
#(
  parameter int N           = 16,
  parameter int B           = DEF_B,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int LEVEL_SHIFT = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0]                  in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*B*B-1:0]              out_block,
  output logic [idx_w(IMG_H/B)-1:0]     out_blk_row,
  output logic [idx_w(IMG_W/B)-1:0]     out_blk_col,
  output logic                          out_last
);

  localparam int BX = IMG_W / B;
  localparam int BY = IMG_H / B;
  localparam int CW = idx_w(IMG_W);
  localparam int RW = idx_w(B);
  localparam int XW = idx_w(BX);
  localparam int YW = idx_w(BY);

  localparam bit GEOM_OK = (IMG_W % B == 0) && (IMG_H % B == 0) && (B >= 2) &&
                           (LEVEL_SHIFT >= 0) && (LEVEL_SHIFT < (1 << N));

  rd_state_t state, state_n;

  logic [CW-1:0]      wcol;
  logic [RW-1:0]      wrow;
  logic               wbank;
  logic               rbank;
  logic [1:0]         full, full_n;
  logic [RW-1:0]      g;
  logic [XW-1:0]      blk_col;
  logic [YW-1:0]      blk_row;
  logic [N*B*B-1:0]   blk_q;
  logic [N-1:0]       wdata;
  logic [N*B-1:0]     rd_row;
  logic [CW-1:0]      rd_base;
  logic               in_fire, out_fire, bank_done, col_last, release_bank, gather_en;

  assign in_ready     = !full[wbank];
  assign in_fire      = in_valid && in_ready;
  assign bank_done    = in_fire && (wrow == RW'(B-1)) && (wcol == CW'(IMG_W-1));
  assign out_fire     = out_valid && out_ready;
  assign col_last     = (blk_col == XW'(BX-1));
  assign release_bank = out_fire && col_last;
  assign rd_base      = CW'(blk_col * B);

`ifdef CC_LEVEL_SHIFT_EN
  assign wdata = in_pixel - N'(LEVEL_SHIFT);
`else
  assign wdata = in_pixel;
`endif

  tile_line_bank #(
    .N     (N),
    .B     (B),
    .IMG_W (IMG_W)
  ) u_bank (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_bank (wbank),
    .wr_row  (wrow),
    .wr_col  (wcol),
    .wr_data (wdata),
    .rd_bank (rbank),
    .rd_row  (g),
    .rd_base (rd_base),
    .rd_data (rd_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wcol  <= '0;
      wrow  <= '0;
      wbank <= 1'b0;
    end else if (in_fire) begin
      if (wcol == CW'(IMG_W-1)) begin
        wcol <= '0;
        if (wrow == RW'(B-1)) begin
          wrow  <= '0;
          wbank <= ~wbank;
        end else begin
          wrow <= wrow + 1'b1;
        end
      end else begin
        wcol <= wcol + 1'b1;
      end
    end
  end

  // Fill and release always target different banks, so both may land together.
  always_comb begin
    full_n = full;
    if (bank_done)    full_n[wbank] = 1'b1;
    if (release_bank) full_n[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) full <= '0;
    else     full <= full_n;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // IDLE also looks at the completing write so the first block is out B+1 cycles
  // after the bank's last pixel, not one cycle later via the registered flag.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (full[rbank] || (bank_done && (wbank == rbank))) state_n = GATHER;
      GATHER:  if (g == RW'(B-1)) state_n = PRESENT;
      PRESENT: if (out_ready) state_n = col_last ? IDLE : GATHER;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    gather_en = 1'b0;
    case (state)
      GATHER:  gather_en = 1'b1;
      PRESENT: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g       <= '0;
      blk_col <= '0;
      blk_row <= '0;
      rbank   <= 1'b0;
      blk_q   <= '0;
    end else begin
      if (gather_en) begin
        g <= (g == RW'(B-1)) ? '0 : g + 1'b1;
        for (int r = 0; r < B; r++) begin
          if (g == RW'(r)) begin
            for (int c = 0; c < B; c++) begin
              blk_q[slice_idx(B, r, c)*N +: N] <= rd_row[(B-1-c)*N +: N];
            end
          end
        end
      end
      if (out_fire) begin
        if (col_last) begin
          blk_col <= '0;
          rbank   <= ~rbank;
          blk_row <= (blk_row == YW'(BY-1)) ? '0 : blk_row + 1'b1;
        end else begin
          blk_col <= blk_col + 1'b1;
        end
      end
    end
  end

  assign out_block   = blk_q;
  assign out_blk_row = blk_row;
  assign out_blk_col = blk_col;
  assign out_last    = out_valid && col_last && (blk_row == YW'(BY-1));

  a_geom: assert property (@(posedge clk) disable iff (rst) GEOM_OK);

endmodule

// File: tb/tb_raster_block_tiler.sv
// Randomised bench for raster_block_tiler against a frame-array reference model.
`timescale 1ns/1ps
module tb_raster_block_tiler;

  localparam int N = 16, B = 8, IMG_W = 128, IMG_H = 128, LEVEL_SHIFT = 128;
  localparam int BX = IMG_W / B, BY = IMG_H / B;
  localparam int FRAME = IMG_W * IMG_H, NBLK = BX * BY, ROW = N * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N-1:0] in_pixel = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [N*B*B-1:0] out_block;
  logic [3:0] out_blk_row, out_blk_col;
  logic out_last;

  always #5 clk = ~clk;

  raster_block_tiler #(
    .N(N), .B(B), .IMG_W(IMG_W), .IMG_H(IMG_H), .LEVEL_SHIFT(LEVEL_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_blk_row(out_blk_row), .out_blk_col(out_blk_col), .out_last(out_last)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_in = 0, n_out = 0, n_last = 0, drv_idx = -1;
  int t_last = -1, t_first = -1, got_first = 0;
  int mode = 0, in_lim = 0, vld_pct = 100, rdy_pct = 100, found = 0;
  logic rdy_at_neg;
  logic [N-1:0] const_val = '0;
  logic [N-1:0] acc_q[$];
  logic [N*B*B-1:0] first_blk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] stored(input logic [N-1:0] v);
`ifdef CC_LEVEL_SHIFT_EN
    return v - N'(LEVEL_SHIFT);
`else
    return v;
`endif
  endfunction

  function automatic logic [N-1:0] gen(input int idx);
    int r, c;
    r = (idx / IMG_W) % IMG_H;
    c = idx % IMG_W;
    case (mode)
      0:       return N'(r * 128 + c);
      1:       return N'($urandom);
      default: return const_val;
    endcase
  endfunction

  // Block n of the stream: frame n/NBLK, raster block order inside the frame.
  function automatic logic [N*B*B-1:0] exp_blk(input int n);
    logic [N*B*B-1:0] v;
    int f, bi, br, bc, idx;
    v  = 'x;
    f  = n / NBLK;
    bi = n % NBLK;
    br = bi / BX;
    bc = bi % BX;
    for (int r = 0; r < B; r++)
      for (int c = 0; c < B; c++) begin
        idx = f * FRAME + (br * B + r) * IMG_W + bc * B + c;
        if (idx < acc_q.size()) v[(B*B-1-(r*B+c))*N +: N] = acc_q[idx];
      end
    return v;
  endfunction

  task automatic check_block();
    logic [N*B*B-1:0] e;
    int bi, br, bc;
    bi = n_out % NBLK;
    br = bi / BX;
    bc = bi % BX;
    e  = exp_blk(n_out);
    for (int k = 0; k < B; k++)
      chk($sformatf("blk%0d_chunk%0d", n_out, k), out_block[k*ROW +: ROW], e[k*ROW +: ROW]);
    chk($sformatf("blk%0d_row", n_out), 128'(out_blk_row), 128'(br));
    chk($sformatf("blk%0d_col", n_out), 128'(out_blk_col), 128'(bc));
    chk($sformatf("blk%0d_last", n_out), 128'(out_last), 128'(br == BY-1 && bc == BX-1));
    if (out_last) n_last++;
    n_out++;
  endtask

  task automatic tick();
    @(negedge clk);
    rdy_at_neg = in_ready;
    if (!rst) begin
      if (in_valid && in_ready) begin
        if (n_in == B * IMG_W - 1) t_last = cyc;
        acc_q.push_back(stored(in_pixel));
        n_in++;
      end
      if (out_valid && t_first < 0) t_first = cyc;
      if (out_valid && got_first == 0) begin
        first_blk = out_block;
        got_first = 1;
      end
      if (out_valid && out_ready) check_block();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive();
    if (n_in != drv_idx) begin
      drv_idx  = n_in;
      in_pixel = gen(n_in);
    end
    in_valid  = (n_in < in_lim) && ($urandom_range(99) < vld_pct);
    out_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic clear_model();
    acc_q.delete();
    n_in = 0; n_out = 0; n_last = 0; drv_idx = -1;
    t_last = -1; t_first = -1; got_first = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    do_reset();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_blk_row", 128'(out_blk_row), 128'(0));
    chk("rst_blk_col", 128'(out_blk_col), 128'(0));
    for (int k = 0; k < B; k++) chk("rst_out_block", out_block[k*ROW +: ROW], '0);

    // Ramp frame with the consumer always ready.
    mode = 0; in_lim = FRAME; vld_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 40000 && n_out < NBLK; i++) begin drive(); tick(); end
    chk("ramp_blocks", 128'(n_out), 128'(NBLK));
    chk("ramp_latency", 128'(t_first - t_last), 128'(B + 1));
    chk("ramp_first_msb", 128'(first_blk[N*B*B-1 -: N]), 128'(stored(N'(0))));
    chk("ramp_first_lsb", 128'(first_blk[N-1:0]), 128'(stored(N'(903))));

    // Second frame back-to-back, random data and handshakes.
    mode = 1; in_lim = 2 * FRAME; vld_pct = 75; rdy_pct = 70;
    for (int i = 0; i < 60000 && n_out < 2 * NBLK; i++) begin drive(); tick(); end
    chk("wrap_blocks", 128'(n_out), 128'(2 * NBLK));
    chk("wrap_last_count", 128'(n_last), 128'(2));

    // Backpressure: consumer stalled from reset.
    do_reset();
    mode = 0; in_lim = FRAME; vld_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 3000 && in_ready; i++) begin drive(); tick(); end
    chk("bp_accepted", 128'(n_in), 128'(2048));
    chk("bp_stalled", 128'(in_ready), 128'(0));
    vld_pct = 0;
    for (int i = 0; i < 50 && !out_valid; i++) begin drive(); tick(); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_one_xfer", 128'(n_out), 128'(1));
    chk("bp_still_stalled", 128'(in_ready), 128'(0));
    rdy_pct = 100;
    for (int i = 0; i < 500 && n_out < BX; i++) begin drive(); tick(); end
    chk("bp_bank_drained", 128'(n_out), 128'(BX));
    chk("bp_rdy_before", 128'(rdy_at_neg), 128'(0));
    chk("bp_rdy_after", 128'(in_ready), 128'(1));

    // Reset while gathering block (3,5), then restream.
    do_reset();
    mode = 0; in_lim = FRAME; vld_pct = 100; rdy_pct = 100; found = 0;
    for (int i = 0; i < 10000 && found == 0; i++) begin
      drive(); tick();
      if (!out_valid && out_blk_row == 4'd3 && out_blk_col == 4'd5) found = 1;
    end
    chk("mid_found_gather", 128'(found), 128'(1));
    rst = 1'b1; in_valid = 1'b0;
    tick();
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 3000 && n_out < BX; i++) begin drive(); tick(); end
    chk("mid_restream", 128'(n_out), 128'(BX));

`ifdef CC_LEVEL_SHIFT_EN
    do_reset();
    mode = 2; const_val = N'(255); in_lim = FRAME; vld_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 2000 && !out_valid; i++) begin drive(); tick(); end
    for (int k = 0; k < B; k++) chk("ls_255", out_block[k*ROW +: ROW], {B{16'h007F}});
    rdy_pct = 100;
    for (int i = 0; i < 100 && n_out < 1; i++) begin drive(); tick(); end
    do_reset();
    mode = 2; const_val = N'(0); in_lim = FRAME; vld_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 2000 && !out_valid; i++) begin drive(); tick(); end
    for (int k = 0; k < B; k++) chk("ls_0", out_block[k*ROW +: ROW], {B{16'hFF80}});
`endif

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_block_tiler.md
Name: raster_block_tiler

Overview:
- Streaming front-end that converts a raster-order pixel stream into B×B blocks for the 2-D DCT (dct2d).
- Replaces bench-side image tiling with synthesizable hardware.
- Ping-pong row banks buffer B image rows. Blocks leave as one flat vector per handshake, in the same packing dct2d consumes on its data_in.
- Generalised over pixel width, block size and image dimensions.

Parameters:
N, 16, signed pixel width in bits
B, 8, block edge; one block = B*B pixels
IMG_W, 128, image width in pixels; must be a multiple of B
IMG_H, 128, image height in pixels; must be a multiple of B
LEVEL_SHIFT, 128, offset subtracted when CC_LEVEL_SHIFT_EN is defined

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  pixel offered
in_ready  out  1  tiler accepts pixel this cycle
in_pixel  in  N  signed pixel, raster order
out_valid  out  1  block vector valid
out_ready  in  1  consumer accepts block
out_block  out  N*B*B  block; pixel (r,c) at slice index (B*B-1-(r*B+c)), so (0,0) is in the MSBs
out_blk_row  out  clog2(IMG_H/B)  block row index of out_block
out_blk_col  out  clog2(IMG_W/B)  block column index of out_block
out_last  out  1  out_block is the final block (bottom-right) of the frame

Behaviour:
- Handshake rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid, out_block and the index outputs hold stable until the output transfer completes.
- Reset: every output is 0 except in_ready=1. All counters are 0, both banks are empty, write bank = 0, read bank = 0, FSM is IDLE. Reset mid-operation discards all partial rows and blocks. The next accepted pixel is frame pixel (0,0).
- Writer:
  - Column counter wcol runs 0..IMG_W-1. Row-in-bank counter wrow runs 0..B-1.
  - On the transfer of pixel (wrow=B-1, wcol=IMG_W-1), the bank is marked full and the writer toggles to the other bank.
  - in_ready = !full[write_bank].
  - The frame row counter wraps at IMG_H; frames run back-to-back with no gap.
- Reader FSM:
  - IDLE: when full[read_bank], go to GATHER with blk_col=0.
  - GATHER: B cycles. Cycle k reads the B pixels of row k, columns blk_col*B..blk_col*B+B-1, into the block register. Go to PRESENT.
  - PRESENT: out_valid=1. On transfer:
    - if blk_col < IMG_W/B-1: increment blk_col, go to GATHER;
    - else: clear full[read_bank], toggle read_bank, increment block row (wrap at IMG_H/B), go to IDLE.
- Latency: last pixel of a bank accepted in cycle t → first block out_valid in cycle t+B+1. With out_ready held high, consecutive blocks from one bank are B+1 cycles apart.
- Simultaneous events:
  - Writer filling bank X in the same cycle the reader releases bank Y: both take effect; there is no lost state.
  - Full release and write-stall de-assert in the same cycle: in_ready rises in the next cycle (registered full flag).
- out_last = 1 only with blk_row=IMG_H/B-1 and blk_col=IMG_W/B-1.
- Width rules: pixels are stored as N-bit signed values.
- Assertions (simulation): IMG_W%B==0, IMG_H%B==0, B≥2.

Optional Feature:
- CC_LEVEL_SHIFT_EN defined: each accepted pixel has LEVEL_SHIFT subtracted before storage. The subtraction is N-bit two's complement and wraps with no saturation. Example: 0 → -128, 255 → 127.
- Undefined: pixels are stored unmodified; the subtractor is absent.

Decomposition:
- Package tiler_pkg holds:
  - reader state enum (IDLE, GATHER, PRESENT);
  - localparams BLKS_X=IMG_W/B and BLKS_Y=IMG_H/B, plus their index widths;
  - the slice-index helper function for the block packing.
- One sub-module, tile_line_bank: two banks of B×IMG_W N-bit entries. It has one pixel write port and one B-pixel row read port (combinational read), plus per-bank full flags owned by the parent.

Test Plan:
- Reset: assert rst for 2 cycles → in_ready=1, out_valid=0, out_block=0, out_last=0 in the cycle after release.
- Ramp frame, pixel = r*128+c, defaults, out_ready=1, macro off:
  - first block (0,0) has MSB slice 0 and LSB slice 903;
  - out_valid appears 9 cycles after accepting pixel (7,127);
  - 256 blocks, in order (0,0)..(15,15).
- Backpressure: out_ready=0 from reset → in_ready falls after exactly 2048 pixels accepted. Raising out_ready for one transfer does not raise in_ready; in_ready rises the cycle after the 16th block of bank 0 transfers.
- Frame wrap: out_last=1 only on block (15,15). The next frame's first block reports (0,0), with data equal to the second frame's pixels.
- Mid-operation reset: assert rst during GATHER of block (3,5) → out_valid=0 the next cycle. Re-streaming from pixel (0,0) yields block (0,0) first with correct data.
- CC_LEVEL_SHIFT_EN defined, constant input 255 → every out_block slice = 127. With input 0 → every slice = -128 (0xFF80).
